id_stage_p: RTL and testbench

- Parametrised successor to the tiny_MIPS instruction-decode stage.
- Holds the register file and decodes the full MIPS subset: add, sub, and, or, slt, lw, sw, beq, bne, j.
- Registers operands and control into the ID/EX (DX) pipeline register.
- Adds valid/stall/flush handshaking, load-use interlock, illegal-instruction flagging and $0 hardwiring.
- Sits between IF (PC, IR) and EX; takes writeback from the MEM/WB stage.

---
 rtl/id_pkg.sv | 36 +++
 rtl/id_regfile.sv | 49 ++++
 rtl/id_stage_p.sv | 170 +++++++++++++++++
 tb/tb_id_stage_p.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct constants,
// the ALU control encoding and the DX control bundle.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctr_e;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic bne;
    logic jump;
  } dx_ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// NREG x XLEN register file: two combinational read ports, one write port,
// $0 hardwired to zero. Optional write-through bypass under ID_RF_BYPASS_EN.
module id_regfile #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int R1_INIT = 1,
  parameter int R2_INIT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [$clog2(NREG)-1:0] raddr_a,
  input  logic [$clog2(NREG)-1:0] raddr_b,
  output logic [XLEN-1:0]         rdata_a,
  output logic [XLEN-1:0]         rdata_b
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_live;

  assign wr_live = we && (waddr != '0);

  // Register array with per-entry reset values; $0 is never written.
  // NOTE: the array is built from flops rather than a RAM macro, so it may take an async reset to seed R1/R2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        if (i == 1)      regs[i] <= XLEN'(R1_INIT);
        else if (i == 2) regs[i] <= XLEN'(R2_INIT);
        else             regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: index 0 reads zero; optionally forward the same-cycle write.
  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
`ifdef ID_RF_BYPASS_EN
    if (wr_live && (waddr == raddr_a)) rdata_a = wdata;
    if (wr_live && (waddr == raddr_b)) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/id_stage_p.sv
// MIPS-subset instruction decode stage with the ID/EX (DX) pipeline register.
// Optional feature: define ID_RF_BYPASS_EN for register-file write-through.
module id_stage_p
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int R1_INIT = 1,
  parameter int R2_INIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            ex_stall,
  input  logic            flush,
  input  logic [XLEN-1:0] PC,
  input  logic [31:0]     IR,
  input  logic            MW_RegWrite,
  input  logic            MW_MemtoReg,
  input  logic [4:0]      MW_RD,
  input  logic [XLEN-1:0] MDR,
  input  logic [XLEN-1:0] MW_ALUout,
  output logic            stall,
  output logic            dx_valid,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            branch,
  output logic            bne,
  output logic            jump,
  output logic [2:0]      ALUctr,
  output logic [XLEN-1:0] JT,
  output logic [XLEN-1:0] DX_PC,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [XLEN-1:0] MD,
  output logic [15:0]     imm,
  output logic [4:0]      RD,
  output logic            illegal
);

  localparam int RW = $clog2(NREG);

  logic [5:0]      opcode, funct;
  logic [XLEN-1:0] rs_val, rt_val, wb_data, sext_imm;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  dx_ctrl_t        dec_ctrl, dx_ctrl;
  alu_ctr_e        dec_alu, dx_alu;
  logic            dec_ill, rt_use, interlock, bubble;

  assign opcode   = IR[31:26];
  assign funct    = IR[5:0];
  assign sext_imm = {{(XLEN-16){IR[15]}}, IR[15:0]};
  assign wb_data  = MW_MemtoReg ? MDR : MW_ALUout;

  id_regfile #(
    .XLEN(XLEN), .NREG(NREG), .R1_INIT(R1_INIT), .R2_INIT(R2_INIT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (MW_RegWrite && (MW_RD != 5'd0)),
    .waddr   (MW_RD[RW-1:0]),
    .wdata   (wb_data),
    .raddr_a (IR[21 +: RW]),
    .raddr_b (IR[16 +: RW]),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  // Instruction decode: control bundle, ALU op, operand B, destination, legality.
  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    dec_ctrl = '0;
    dec_alu  = ALU_ADD;
    dec_b    = rt_val;
    dec_rd   = 5'd0;
    dec_ill  = 1'b0;
    rt_use   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rt_use             = 1'b1;
        dec_rd             = IR[15:11];
        dec_ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec_alu = ALU_ADD;
          FN_SUB:  dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_SLT:  dec_alu = ALU_SLT;
          default: begin
            dec_ill  = 1'b1;
            dec_ctrl = '0;
          end
        endcase
      end
      OP_LW: begin
        dec_b               = sext_imm;
        dec_rd              = IR[20:16];
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        rt_use             = 1'b1;
        dec_b              = sext_imm;
        dec_ctrl.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        rt_use          = 1'b1;
        dec_alu         = ALU_SUB;
        dec_ctrl.branch = 1'b1;
        dec_ctrl.bne    = (opcode == OP_BNE);
      end
      OP_J:    dec_ctrl.jump = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  // Load-use interlock against the load sitting in DX; EX backpressure also stalls IF.
  always_comb begin
    interlock = id_valid && dx_valid && dx_ctrl.mem_read && (RD != 5'd0) &&
                ((RD == IR[25:21]) || (rt_use && (RD == IR[20:16])));
    stall     = ex_stall || interlock;
    bubble    = flush || interlock || !id_valid || dec_ill;
  end

  // DX pipeline register: hold on ex_stall, otherwise load data and gate control on bubbles.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx_valid <= 1'b0;
      dx_ctrl  <= '0;
      dx_alu   <= ALU_ADD;
      JT       <= '0;
      DX_PC    <= '0;
      A        <= '0;
      B        <= '0;
      MD       <= '0;
      imm      <= '0;
      RD       <= '0;
      illegal  <= 1'b0;
    end else if (ex_stall) begin
      illegal <= 1'b0;
    end else begin
      JT       <= {PC[XLEN-1:28], IR[25:0], 2'b00};
      DX_PC    <= PC;
      A        <= rs_val;
      B        <= dec_b;
      MD       <= rt_val;
      imm      <= IR[15:0];
      RD       <= dec_rd;
      dx_valid <= !bubble;
      dx_ctrl  <= bubble ? '0 : dec_ctrl;
      dx_alu   <= bubble ? ALU_ADD : dec_alu;
      illegal  <= id_valid && dec_ill && !flush && !interlock;
    end
  end

  assign MemtoReg = dx_ctrl.mem_to_reg;
  assign RegWrite = dx_ctrl.reg_write;
  assign MemRead  = dx_ctrl.mem_read;
  assign MemWrite = dx_ctrl.mem_write;
  assign branch   = dx_ctrl.branch;
  assign bne      = dx_ctrl.bne;
  assign jump     = dx_ctrl.jump;
  assign ALUctr   = dx_alu;

endmodule

// File: tb/tb_id_stage_p.sv
// Scoreboard bench for id_stage_p: the driver pushes the expected DX contents
// for each cycle it issues; a monitor pops and compares after each clock edge.
module tb_id_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, ex_stall, flush;
  logic [31:0] PC, IR;
  logic        MW_RegWrite, MW_MemtoReg;
  logic [4:0]  MW_RD;
  logic [31:0] MDR, MW_ALUout;
  logic        stall, dx_valid, MemtoReg, RegWrite, MemRead, MemWrite;
  logic        branch, bne, jump, illegal;
  logic [2:0]  ALUctr;
  logic [31:0] JT, DX_PC, A, B, MD;
  logic [15:0] imm;
  logic [4:0]  RD;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage_p dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ex_stall(ex_stall), .flush(flush),
    .PC(PC), .IR(IR), .MW_RegWrite(MW_RegWrite), .MW_MemtoReg(MW_MemtoReg),
    .MW_RD(MW_RD), .MDR(MDR), .MW_ALUout(MW_ALUout), .stall(stall),
    .dx_valid(dx_valid), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .branch(branch), .bne(bne), .jump(jump), .ALUctr(ALUctr),
    .JT(JT), .DX_PC(DX_PC), .A(A), .B(B), .MD(MD), .imm(imm), .RD(RD), .illegal(illegal)
  );

  typedef struct {
    string       name;
    bit          chk_data, chk_md, chk_jt;
    logic        dxv, ill;
    logic [6:0]  ctrl;
    logic [2:0]  alu;
    logic [31:0] a, b, md, jt, pc;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];

  // Control bundle order: {MemtoReg,RegWrite,MemRead,MemWrite,branch,bne,jump}
  localparam logic [6:0] C_ADD = 7'b0100000;
  localparam logic [6:0] C_LW  = 7'b1110000;
  localparam logic [6:0] C_SW  = 7'b0001000;
  localparam logic [6:0] C_BEQ = 7'b0000100;
  localparam logic [6:0] C_BNE = 7'b0000110;
  localparam logic [6:0] C_J   = 7'b0000001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic exp_t ev(input string n, input logic [6:0] c, input logic [2:0] alu,
                              input logic [31:0] a, b, input logic [4:0] rd, input logic [31:0] pc);
    exp_t e;
    e.name = n; e.chk_data = 1; e.chk_md = 0; e.chk_jt = 0;
    e.dxv = 1'b1; e.ill = 1'b0; e.ctrl = c; e.alu = alu;
    e.a = a; e.b = b; e.md = '0; e.jt = '0; e.rd = rd; e.pc = pc;
    return e;
  endfunction

  function automatic exp_t bub(input string n, input logic ill);
    exp_t e;
    e = ev(n, 7'd0, 3'd0, '0, '0, 5'd0, '0);
    e.chk_data = 0; e.dxv = 1'b0; e.ill = ill;
    return e;
  endfunction

  // Pending writeback applied by the next issued cycle, then cleared.
  logic        p_wr, p_m2r;
  logic [4:0]  p_rd;
  logic [31:0] p_mdr, p_alu;

  task automatic set_wb(input logic m2r, input logic [4:0] rd, input logic [31:0] mdr, alu);
    p_wr = 1'b1; p_m2r = m2r; p_rd = rd; p_mdr = mdr; p_alu = alu;
  endtask

  task automatic cyc(input logic [31:0] ir, pc, input logic v, fl, es, exp_stall, input exp_t e);
    @(negedge clk);
    IR = ir; PC = pc; id_valid = v; flush = fl; ex_stall = es;
    MW_RegWrite = p_wr; MW_MemtoReg = p_m2r; MW_RD = p_rd; MDR = p_mdr; MW_ALUout = p_alu;
    p_wr = 1'b0; p_m2r = 1'b0; p_rd = 5'd0; p_mdr = '0; p_alu = '0;
    #1;
    check({"stall ", e.name}, {31'd0, stall}, {31'd0, exp_stall});
    q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare DX state against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({"dx_valid ", e.name}, {31'd0, dx_valid}, {31'd0, e.dxv});
        check({"illegal ", e.name}, {31'd0, illegal}, {31'd0, e.ill});
        check({"ctrl ", e.name},
              {25'd0, MemtoReg, RegWrite, MemRead, MemWrite, branch, bne, jump},
              {25'd0, e.ctrl});
        if (e.chk_data) begin
          check({"A ", e.name}, A, e.a);
          check({"B ", e.name}, B, e.b);
          check({"RD ", e.name}, {27'd0, RD}, {27'd0, e.rd});
          check({"ALUctr ", e.name}, {29'd0, ALUctr}, {29'd0, e.alu});
          check({"DX_PC ", e.name}, DX_PC, e.pc);
        end
        if (e.chk_md) check({"MD ", e.name}, MD, e.md);
        if (e.chk_jt) check({"JT ", e.name}, JT, e.jt);
      end
    end
  end

  initial begin
    exp_t e, last;
    logic [31:0] ill_op;
    logic [31:0] bypass_exp;
    ill_op = 32'hFC00_0000;
`ifdef ID_RF_BYPASS_EN
    bypass_exp = 32'h55;
`else
    bypass_exp = 32'h0;
`endif
    p_wr = 1'b0; p_m2r = 1'b0; p_rd = 5'd0; p_mdr = '0; p_alu = '0;
    rst = 1'b0; id_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    PC = '0; IR = '0; MW_RegWrite = 1'b0; MW_MemtoReg = 1'b0; MW_RD = 5'd0;
    MDR = '0; MW_ALUout = '0;
    repeat (2) @(negedge clk);
    check("reset dx_valid", {31'd0, dx_valid}, 32'd0);
    check("reset illegal", {31'd0, illegal}, 32'd0);
    check("reset ctrl", {25'd0, MemtoReg, RegWrite, MemRead, MemWrite, branch, bne, jump}, 32'd0);
    check("reset data", A | B | MD | JT | DX_PC | {16'd0, imm} | {27'd0, RD} | {29'd0, ALUctr}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    rst = 1'b1;

    // Basic R-type and load-use on rs
    e = ev("add", C_ADD, 3'd0, 32'd1, 32'd2, 5'd3, 32'h100); e.chk_md = 1; e.md = 32'd2;
    cyc(r_type(5'd1, 5'd2, 5'd3, 6'd32), 32'h100, 1, 0, 0, 0, e);
    cyc(i_type(6'd35, 5'd1, 5'd4, 16'd8), 32'h104, 1, 0, 0, 0,
        ev("lw4", C_LW, 3'd0, 32'd1, 32'd8, 5'd4, 32'h104));
    cyc(r_type(5'd4, 5'd2, 5'd5, 6'd34), 32'h108, 1, 0, 0, 1, bub("sub_interlock", 0));
    cyc(r_type(5'd4, 5'd2, 5'd5, 6'd34), 32'h108, 1, 0, 0, 0,
        ev("sub", C_ADD, 3'd1, 32'd0, 32'd2, 5'd5, 32'h108));

    // rt hazard only for rt consumers
    cyc(i_type(6'd35, 5'd0, 5'd8, 16'd0), 32'h10C, 1, 0, 0, 0,
        ev("lw8a", C_LW, 3'd0, 32'd0, 32'd0, 5'd8, 32'h10C));
    cyc(i_type(6'd35, 5'd2, 5'd8, 16'd0), 32'h110, 1, 0, 0, 0,
        ev("lw8b_no_rt_hazard", C_LW, 3'd0, 32'd2, 32'd0, 5'd8, 32'h110));
    cyc(i_type(6'd4, 5'd0, 5'd8, 16'd4), 32'h114, 1, 0, 0, 1, bub("beq_interlock", 0));
    cyc(i_type(6'd4, 5'd0, 5'd8, 16'd4), 32'h114, 1, 0, 0, 0,
        ev("beq", C_BEQ, 3'd1, 32'd0, 32'd0, 5'd0, 32'h114));
    cyc(i_type(6'd5, 5'd1, 5'd2, 16'hFFFF), 32'h118, 1, 0, 0, 0,
        ev("bne", C_BNE, 3'd1, 32'd1, 32'd2, 5'd0, 32'h118));

    // Load to $0 never interlocks; id_valid=0 never interlocks
    cyc(i_type(6'd35, 5'd1, 5'd0, 16'd0), 32'h11C, 1, 0, 0, 0,
        ev("lw0", C_LW, 3'd0, 32'd1, 32'd0, 5'd0, 32'h11C));
    cyc(r_type(5'd0, 5'd0, 5'd3, 6'd32), 32'h120, 1, 0, 0, 0,
        ev("add_after_lw0", C_ADD, 3'd0, 32'd0, 32'd0, 5'd3, 32'h120));
    cyc(i_type(6'd35, 5'd1, 5'd7, 16'd0), 32'h124, 1, 0, 0, 0,
        ev("lw7", C_LW, 3'd0, 32'd1, 32'd0, 5'd7, 32'h124));
    cyc(r_type(5'd7, 5'd7, 5'd3, 6'd32), 32'h128, 0, 0, 0, 0, bub("idle_no_interlock", 0));

    // Store with negative offset, remaining ALU ops
    e = ev("sw", C_SW, 3'd0, 32'd1, 32'hFFFF_FFFC, 5'd0, 32'h200); e.chk_md = 1; e.md = 32'd2;
    cyc(i_type(6'd43, 5'd1, 5'd2, 16'hFFFC), 32'h200, 1, 0, 0, 0, e);
    cyc(r_type(5'd1, 5'd2, 5'd3, 6'd36), 32'h204, 1, 0, 0, 0,
        ev("and", C_ADD, 3'd2, 32'd1, 32'd2, 5'd3, 32'h204));
    cyc(r_type(5'd1, 5'd2, 5'd3, 6'd37), 32'h208, 1, 0, 0, 0,
        ev("or", C_ADD, 3'd3, 32'd1, 32'd2, 5'd3, 32'h208));
    cyc(r_type(5'd2, 5'd1, 5'd3, 6'd42), 32'h20C, 1, 0, 0, 0,
        ev("slt", C_ADD, 3'd4, 32'd2, 32'd1, 5'd3, 32'h20C));

    // Jump target and flush
    e = ev("j", C_J, 3'd0, 32'd0, 32'd0, 5'd0, 32'h3000_0010);
    e.chk_data = 0; e.chk_jt = 1; e.jt = 32'h3000_0100;
    cyc({6'd2, 26'h40}, 32'h3000_0010, 1, 0, 0, 0, e);
    cyc({6'd2, 26'h40}, 32'h3000_0010, 1, 1, 0, 0, bub("j_flush", 0));

    // Writes to $0 are dropped
    set_wb(1'b0, 5'd0, 32'd0, 32'hFFFF);
    cyc(32'd0, 32'h300, 0, 0, 0, 0, bub("wb_r0", 0));
    cyc(r_type(5'd0, 5'd1, 5'd3, 6'd32), 32'h304, 1, 0, 0, 0,
        ev("read_r0", C_ADD, 3'd0, 32'd0, 32'd1, 5'd3, 32'h304));

    // Illegal opcode / funct, pulse width, suppression by flush
    cyc(ill_op, 32'h308, 1, 0, 0, 0, bub("illegal_op", 1));
    cyc(32'd0, 32'h30C, 0, 0, 0, 0, bub("illegal_clear", 0));
    cyc(r_type(5'd1, 5'd2, 5'd3, 6'd33), 32'h310, 1, 0, 0, 0, bub("illegal_funct", 1));
    cyc(ill_op, 32'h314, 1, 1, 0, 0, bub("illegal_flushed", 0));

    // ex_stall holds DX and suppresses illegal
    last = ev("hold_base", C_ADD, 3'd0, 32'd1, 32'd2, 5'd3, 32'h318);
    cyc(r_type(5'd1, 5'd2, 5'd3, 6'd32), 32'h318, 1, 0, 0, 0, last);
    last.name = "ex_stall_hold";
    cyc(r_type(5'd1, 5'd2, 5'd5, 6'd34), 32'h31C, 1, 0, 1, 1, last);
    last.name = "ex_stall_illegal";
    cyc(ill_op, 32'h320, 1, 0, 1, 1, last);

    // Same-cycle writeback/read of $6, then MDR writeback path
    set_wb(1'b0, 5'd6, 32'd0, 32'h55);
    cyc(r_type(5'd6, 5'd0, 5'd7, 6'd32), 32'h324, 1, 0, 0, 0,
        ev("wb_same_cycle", C_ADD, 3'd0, bypass_exp, 32'd0, 5'd7, 32'h324));
    cyc(r_type(5'd6, 5'd0, 5'd7, 6'd32), 32'h328, 1, 0, 0, 0,
        ev("wb_after", C_ADD, 3'd0, 32'h55, 32'd0, 5'd7, 32'h328));
    set_wb(1'b1, 5'd9, 32'hABCD, 32'h1111);
    cyc(32'd0, 32'h32C, 0, 0, 0, 0, bub("wb_mdr", 0));
    cyc(r_type(5'd9, 5'd1, 5'd3, 6'd32), 32'h330, 1, 0, 0, 0,
        ev("read_mdr", C_ADD, 3'd0, 32'hABCD, 32'd1, 5'd3, 32'h330));

    @(negedge clk);
    id_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    check("scoreboard drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
